// File: rtl/vec_mem_pkg.sv
// Shared constants and types for the vector load/store sequencer.
// Region bounds are word addresses; lanes are S_W bits wide.
package vec_mem_pkg;

  localparam int unsigned S_W   = 32;
  localparam int unsigned V_W   = 192;
  localparam int unsigned LANES = 6;

  localparam logic [31:0] ROM_LO = 32'd1000;
  localparam logic [31:0] RAM_LO = 32'd151000;
  localparam logic [31:0] RAM_HI = 32'd301000;

  localparam logic [LANES-1:0] FULL_MASK = 6'h3F;

  typedef enum logic [1:0] {
    IDLE,
    UNIT,
    ELEM,
    RESP
  } lsu_state_t;

  typedef logic [S_W-1:0] lane_t;

endpackage

// File: rtl/vec_lsu_sequencer_if.sv
// Pipeline-side request/response bundle and controller-side memory bundle.
// Master drives the request (or the memory access); slave answers it.
interface vec_req_if #(
  parameter int unsigned S = 32,
  parameter int unsigned V = 192
);
  logic         req_valid;
  logic         req_ready;
  logic         req_store;
  logic [S-1:0] req_base;
  logic [S-1:0] req_stride;
  logic [5:0]   req_mask;
  logic [V-1:0] req_wdata;
  logic         resp_valid;
  logic [V-1:0] resp_rdata;
  logic         resp_err;

  modport master (
    output req_valid, req_store, req_base, req_stride, req_mask, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_base, req_stride, req_mask, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface vec_mem_if #(
  parameter int unsigned S = 32,
  parameter int unsigned V = 192
);
  logic         mem_we;
  logic         mem_vecop;
  logic [V-1:0] mem_address;
  logic [V-1:0] mem_wd;
  logic [V-1:0] mem_rd;

  modport master (
    output mem_we, mem_vecop, mem_address, mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_we, mem_vecop, mem_address, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/vec_addr_gen.sv
// Lane address (base + lane*stride, wrapping at 2^32) and region legality.
// Loads may touch ROM or RAM; stores only RAM.
module vec_addr_gen
  import vec_mem_pkg::*;
(
  input  lane_t      base,
  input  lane_t      stride,
  input  logic [2:0] lane,
  input  logic       store,
  output lane_t      addr,
  output logic       legal
);

  always_comb begin
    addr  = base + lane_t'(lane) * stride;
    legal = (addr < RAM_HI) && (addr >= (store ? RAM_LO : ROM_LO));
  end

endmodule

// File: rtl/vec_lsu_sequencer.sv
// Sequences one pipeline load/store into either a single 192-bit access
// or six per-lane scalar accesses, then returns a one-cycle response.
module vec_lsu_sequencer
  import vec_mem_pkg::*;
#(
  parameter int unsigned S = S_W,
  parameter int unsigned V = V_W
)(
  input  logic       clk,
  input  logic       rst_n,
  vec_req_if.slave   req,
  vec_mem_if.master  mem
);

  lsu_state_t   state;
  logic [2:0]   cnt;
  logic         store_q;
  lane_t        base_q;
  lane_t        stride_q;
  logic [5:0]   mask_q;
  logic [V-1:0] wdata_q;
  logic         err_q;
  logic         active_q;
  logic         ready_q;
  logic         resp_valid_q;
  logic         resp_err_q;
  logic [V-1:0] rdata_q;
  logic         mem_we_q;
  logic         mem_vecop_q;
  logic [V-1:0] mem_address_q;
  logic [V-1:0] mem_wd_q;

  logic         idle;
  lane_t        src_base;
  lane_t        src_stride;
  logic         src_store;
  logic [5:0]   src_mask;
  logic [V-1:0] src_wdata;
  logic [2:0]   nlane;
  lane_t        n_addr;
  lane_t        l5_addr;
  logic         n_legal;
  logic         l5_legal;
  logic         n_hit;
  logic         n_fault;
  logic         unit_ok;
  logic [V-1:0] n_address;
  logic [V-1:0] n_wd;

  // Outputs are registered, so the lane evaluated here is the one that will
  // be on the bus next cycle: lane 0 from the live request while idle,
  // otherwise cnt+1 from the captured request.
  always_comb begin
    idle       = (state == IDLE);
    src_base   = idle ? req.req_base   : base_q;
    src_stride = idle ? req.req_stride : stride_q;
    src_store  = idle ? req.req_store  : store_q;
    src_mask   = idle ? req.req_mask   : mask_q;
    src_wdata  = idle ? req.req_wdata  : wdata_q;
    nlane      = (idle || cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
  end

  vec_addr_gen u_cur (
    .base   (src_base),
    .stride (src_stride),
    .lane   (nlane),
    .store  (src_store),
    .addr   (n_addr),
    .legal  (n_legal)
  );

  vec_addr_gen u_l5 (
    .base   (req.req_base),
    .stride (req.req_stride),
    .lane   (3'd5),
    .store  (req.req_store),
    .addr   (l5_addr),
    .legal  (l5_legal)
  );

  always_comb begin
    n_hit     = src_mask[nlane] && n_legal;
    n_fault   = src_mask[nlane] && !n_legal;
    n_address = '0;
    n_wd      = '0;
    if (n_hit) begin
      n_address[S-1:0] = n_addr;
      if (src_store) n_wd[S-1:0] = src_wdata[S*nlane +: S];
    end
    unit_ok = (req.req_stride == lane_t'(1)) && (req.req_mask == FULL_MASK) &&
              n_legal && l5_legal && ((n_addr >= RAM_LO) == (l5_addr >= RAM_LO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      store_q       <= 1'b0;
      base_q        <= '0;
      stride_q      <= '0;
      mask_q        <= '0;
      wdata_q       <= '0;
      err_q         <= 1'b0;
      active_q      <= 1'b0;
      ready_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      rdata_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_vecop_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wd_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          if (req.req_valid && ready_q) begin
            ready_q  <= 1'b0;
            store_q  <= req.req_store;
            base_q   <= req.req_base;
            stride_q <= req.req_stride;
            mask_q   <= req.req_mask;
            wdata_q  <= req.req_wdata;
            rdata_q  <= '0;
            cnt      <= '0;
            if (unit_ok) begin
              state         <= UNIT;
              err_q         <= 1'b0;
              active_q      <= 1'b1;
              mem_we_q      <= req.req_store;
              mem_vecop_q   <= 1'b1;
              mem_address_q <= {{(V-S){1'b0}}, req.req_base};
              mem_wd_q      <= req.req_wdata;
            end else begin
              state         <= ELEM;
              err_q         <= n_fault;
              active_q      <= n_hit;
              mem_we_q      <= n_hit && req.req_store;
              mem_vecop_q   <= 1'b0;
              mem_address_q <= n_address;
              mem_wd_q      <= n_wd;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end

        UNIT: begin
          if (!store_q) rdata_q <= mem.mem_rd;
          state         <= RESP;
          resp_valid_q  <= 1'b1;
          resp_err_q    <= 1'b0;
          mem_we_q      <= 1'b0;
          mem_vecop_q   <= 1'b0;
          mem_address_q <= '0;
          mem_wd_q      <= '0;
        end

        ELEM: begin
          if (!store_q && active_q) rdata_q[S*cnt +: S] <= mem.mem_rd[S-1:0];
          if (cnt == 3'd5) begin
            state         <= RESP;
            resp_valid_q  <= 1'b1;
            resp_err_q    <= err_q;
            active_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wd_q      <= '0;
          end else begin
            cnt           <= cnt + 3'd1;
            err_q         <= err_q | n_fault;
            active_q      <= n_hit;
            mem_we_q      <= n_hit && store_q;
            mem_address_q <= n_address;
            mem_wd_q      <= n_wd;
          end
          mem_vecop_q <= 1'b0;
        end

        RESP: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          ready_q      <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign req.req_ready   = ready_q;
  assign req.resp_valid  = resp_valid_q;
  assign req.resp_rdata  = rdata_q;
  assign req.resp_err    = resp_err_q;
  assign mem.mem_we      = mem_we_q;
  assign mem.mem_vecop   = mem_vecop_q;
  assign mem.mem_address = mem_address_q;
  assign mem.mem_wd      = mem_wd_q;

endmodule

// File: tb/tb_vec_lsu_sequencer.sv
// Directed vector bench for vec_lsu_sequencer with a combinational memory
// whose read data is a fixed function of the presented address.
module tb_vec_lsu_sequencer;
  import vec_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_req_if #(.S(32), .V(192)) rif ();
  vec_mem_if #(.S(32), .V(192)) mif ();

  vec_lsu_sequencer #(.S(32), .V(192)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rif),
    .mem   (mif)
  );

  function automatic logic [191:0] rdfun(input logic [31:0] a);
    logic [191:0] r;
    for (int j = 0; j < 6; j++) r[32*j +: 32] = (a + 32'(j)) ^ 32'h5A00_0000;
    return r;
  endfunction

  assign mif.mem_rd = rdfun(mif.mem_address[31:0]);

  typedef struct packed {
    logic              store;
    logic [31:0]       base;
    logic [31:0]       stride;
    logic [5:0]        mask;
    logic              unit;
    logic              err;
    logic [5:0][31:0]  addr;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [31:0] b, input logic [31:0] s,
                              input logic [5:0] m, input logic u, input logic e,
                              input logic [31:0] a0, a1, a2, a3, a4, a5);
    vec_t v;
    v.store = st; v.base = b; v.stride = s; v.mask = m; v.unit = u; v.err = e;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.addr[3] = a3; v.addr[4] = a4; v.addr[5] = a5;
    return v;
  endfunction

  int n_vec = 0;
  int n_bad = 0;
  logic [191:0] wd_v;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, output logic ok);
    int w = 0;
    while (!rif.req_ready && w < 20) begin
      tick();
      w++;
    end
    ok = rif.req_ready;
    if (!ok) chk({tag, " ready timeout"}, {191'd0, rif.req_ready}, 192'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic ok;
    logic got;
    int lat;
    int k;
    logic [191:0] erd;
    logic [191:0] tmp;
    logic [191:0] ewd;
    rif.req_store  = v.store;
    rif.req_base   = v.base;
    rif.req_stride = v.stride;
    rif.req_mask   = v.mask;
    rif.req_wdata  = wd_v;
    rif.req_valid  = 1'b1;
    wait_ready(tag, ok);
    if (!ok) begin
      rif.req_valid = 1'b0;
      return;
    end
    tick();
    rif.req_valid = 1'b0;

    erd = '0;
    if (!v.store) begin
      if (v.unit) erd = rdfun(v.base);
      else
        for (int i = 0; i < 6; i++)
          if (v.addr[i] != 32'd0) begin
            tmp = rdfun(v.addr[i]);
            erd[32*i +: 32] = tmp[31:0];
          end
    end

    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      if (rif.resp_valid) begin
        got = 1'b1;
        lat = c;
      end else begin
        k = c - 1;
        chk({tag, " busy ready"}, {191'd0, rif.req_ready}, 192'd0);
        if (v.unit && c == 1) begin
          chk({tag, " unit vecop"}, {191'd0, mif.mem_vecop}, 192'd1);
          chk({tag, " unit addr"}, mif.mem_address, {160'd0, v.base});
          chk({tag, " unit we"}, {191'd0, mif.mem_we}, {191'd0, v.store});
          chk({tag, " unit wd"}, mif.mem_wd, wd_v);
        end else if (!v.unit && k < 6) begin
          ewd = '0;
          if (v.store && v.addr[k] != 32'd0) ewd[31:0] = wd_v[32*k +: 32];
          chk($sformatf("%s lane%0d vecop", tag, k), {191'd0, mif.mem_vecop}, 192'd0);
          chk($sformatf("%s lane%0d addr", tag, k), mif.mem_address, {160'd0, v.addr[k]});
          chk($sformatf("%s lane%0d we", tag, k), {191'd0, mif.mem_we},
              {191'd0, v.store && v.addr[k] != 32'd0});
          chk($sformatf("%s lane%0d wd", tag, k), mif.mem_wd, ewd);
        end
        tick();
      end
    end
    chk({tag, " latency"}, 192'(lat), v.unit ? 192'd2 : 192'd7);
    if (got) begin
      chk({tag, " err"}, {191'd0, rif.resp_err}, {191'd0, v.err});
      chk({tag, " rdata"}, rif.resp_rdata, erd);
      chk({tag, " resp mem_we"}, {191'd0, mif.mem_we}, 192'd0);
      tick();
      chk({tag, " pulse end"}, {191'd0, rif.resp_valid}, 192'd0);
      chk({tag, " ready back"}, {191'd0, rif.req_ready}, 192'd1);
    end
  endtask

  initial begin
    logic ok;
    logic seen;
    int pulses;
    logic [7:0] exp_ready;
    wd_v = {32'hF5F5_0505, 32'hE4E4_0404, 32'hD3D3_0303,
            32'hC2C2_0202, 32'hB1B1_0101, 32'hA0A0_0000};
    tbl[0]  = mk(1'b0, 32'd1000,   32'd1, 6'h3F, 1'b1, 1'b0, 32'd1000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1'b1, 32'd151000, 32'd2, 6'h3F, 1'b0, 1'b0,
                 32'd151000, 32'd151002, 32'd151004, 32'd151006, 32'd151008, 32'd151010);
    tbl[2]  = mk(1'b1, 32'd150998, 32'd1, 6'h3F, 1'b0, 1'b1,
                 0, 0, 32'd151000, 32'd151001, 32'd151002, 32'd151003);
    tbl[3]  = mk(1'b0, 32'd2000, 32'hFFFF_FFFF, 6'b000101, 1'b0, 1'b0,
                 32'd2000, 0, 32'd1998, 0, 0, 0);
    tbl[4]  = mk(1'b0, 32'd0, 32'd1, 6'h3F, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1'b0, 32'd160000, 32'd1, 6'h00, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1'b1, 32'd151000, 32'd1, 6'h3F, 1'b1, 1'b0, 32'd151000, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1'b0, 32'd150995, 32'd1, 6'h3F, 1'b0, 1'b0,
                 32'd150995, 32'd150996, 32'd150997, 32'd150998, 32'd150999, 32'd151000);
    tbl[8]  = mk(1'b0, 32'd300995, 32'd1, 6'h3F, 1'b0, 1'b1,
                 32'd300995, 32'd300996, 32'd300997, 32'd300998, 32'd300999, 0);
    tbl[9]  = mk(1'b1, 32'd151000, 32'd1, 6'h3E, 1'b0, 1'b0,
                 0, 32'd151001, 32'd151002, 32'd151003, 32'd151004, 32'd151005);
    tbl[10] = mk(1'b0, 32'hFFFF_FFFF, 32'd1001, 6'b000011, 1'b0, 1'b1,
                 0, 32'd1000, 0, 0, 0, 0);
    tbl[11] = mk(1'b1, 32'd1000, 32'd1, 6'h3F, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);

    rif.req_valid = 1'b0; rif.req_store = 1'b0; rif.req_base = '0;
    rif.req_stride = '0; rif.req_mask = '0; rif.req_wdata = '0;

    #1;
    chk("reset ready", {191'd0, rif.req_ready}, 192'd0);
    chk("reset resp_valid", {191'd0, rif.resp_valid}, 192'd0);
    chk("reset mem_we", {191'd0, mif.mem_we}, 192'd0);
    chk("reset mem_address", mif.mem_address, 192'd0);
    chk("reset rdata", rif.resp_rdata, 192'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset ready", {191'd0, rif.req_ready}, 192'd1);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset asserted while lane 3 of a strided store is on the bus.
    rif.req_store = 1'b1; rif.req_base = 32'd151000; rif.req_stride = 32'd2;
    rif.req_mask = 6'h3F; rif.req_wdata = wd_v; rif.req_valid = 1'b1;
    wait_ready("rst", ok);
    tick();
    rif.req_valid = 1'b0;
    repeat (3) tick();
    chk("rst lane3 we", {191'd0, mif.mem_we}, 192'd1);
    chk("rst lane3 addr", mif.mem_address, 192'd151006);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async we", {191'd0, mif.mem_we}, 192'd0);
    chk("rst async addr", mif.mem_address, 192'd0);
    chk("rst async ready", {191'd0, rif.req_ready}, 192'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rif.resp_valid) seen = 1'b1;
    end
    chk("rst no resp", {191'd0, seen}, 192'd0);
    chk("rst ready after", {191'd0, rif.req_ready}, 192'd1);

    // req_valid held high: only sampled while idle, one unit load per 3 cycles.
    rif.req_store = 1'b0; rif.req_base = 32'd1000; rif.req_stride = 32'd1;
    rif.req_mask = 6'h3F; rif.req_valid = 1'b1;
    pulses = 0;
    exp_ready = 8'b0010_0100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("hold ready c%0d", c), {191'd0, rif.req_ready}, {191'd0, exp_ready[c-1]});
      if (rif.resp_valid) pulses++;
    end
    rif.req_valid = 1'b0;
    chk("hold pulses", 192'(pulses), 192'd3);

    run_vec(tbl[3], "after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
